// File: rtl/cv_seq_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cv_seq_sched : load/step strobe scheduler with optional timed auto-burst   |
// | Auto stepping is built only with CV_SEQ_SCHED_AUTO_EN defined.             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module cv_seq_sched #(
  parameter int PER_W   = 10,
  parameter int BURST_N = 8
) (
  input  logic             CLK,
  input  logic             SYS_NRST,
  input  logic             CE,
  input  logic             LOAD_REQ,
  input  logic             STEP_REQ,
  input  logic             RUN_REQ,
  input  logic [PER_W-1:0] PERIOD,
  output logic             LOAD,
  output logic             STEP,
  output logic             SHIFT,
  output logic             RUN,
  output logic [3:0]       STEP_CNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam logic [3:0] c_CNT_MAX = 4'd15;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_load;
  logic       r_step;
  logic [3:0] r_step_cnt;
  logic       w_step_man;
  logic       w_step_auto;
  logic       w_step_acc;
  logic       w_run_tgl;
  logic       w_burst_done;

  // A load request always wins over any step in the same cycle.
  assign w_step_man = STEP_REQ && (r_state != S_IDLE) && !LOAD_REQ;
  assign w_step_acc = w_step_man || w_step_auto;

`ifdef CV_SEQ_SCHED_AUTO_EN
  localparam logic [3:0] c_BURST = 4'(BURST_N);

  logic [PER_W-1:0] r_tick;
  logic [3:0]       r_burst;
  logic [PER_W:0]   w_per_eff;
  logic [PER_W:0]   w_tick_inc;
  logic             w_in_run;
  logic             w_fire;

  assign w_in_run     = (r_state == S_RUN);
  assign w_run_tgl    = RUN_REQ && (r_state != S_IDLE);
  assign w_per_eff    = (PERIOD == '0) ? (PER_W+1)'(1) : {1'b0, PERIOD};
  assign w_tick_inc   = {1'b0, r_tick} + (PER_W+1)'(1);
  // >= so that a period shortened below the running count fires on the next tick
  assign w_fire       = w_in_run && CE && (w_tick_inc >= w_per_eff);
  assign w_step_auto  = w_fire && !RUN_REQ && !LOAD_REQ;
  assign w_burst_done = w_step_auto && (r_burst == (c_BURST - 4'd1));
  assign RUN          = w_in_run;

  always_ff @(posedge CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      r_tick  <= '0;
      r_burst <= '0;
    end else if (!w_in_run) begin
      r_tick  <= '0;
      r_burst <= '0;
    end else begin
      if (LOAD_REQ || RUN_REQ || w_step_acc)
        r_tick <= '0;
      else if (CE)
        r_tick <= w_tick_inc[PER_W-1:0];
      if (w_step_auto)
        r_burst <= r_burst + 4'd1;
    end
  end
`else
  logic w_unused;

  assign w_unused     = ^{CE, RUN_REQ, PERIOD, 4'(BURST_N)};
  assign w_run_tgl    = 1'b0;
  assign w_step_auto  = 1'b0;
  assign w_burst_done = 1'b0;
  assign RUN          = 1'b0;
`endif

  always_ff @(posedge CLK or negedge SYS_NRST) begin
    if (!SYS_NRST)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (LOAD_REQ)
          w_state_nxt = S_READY;
      end
      S_READY: begin
        if (w_run_tgl)
          w_state_nxt = S_RUN;
      end
`ifdef CV_SEQ_SCHED_AUTO_EN
      S_RUN: begin
        if (w_run_tgl || w_burst_done)
          w_state_nxt = S_READY;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      r_load     <= 1'b0;
      r_step     <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_load <= LOAD_REQ;
      r_step <= w_step_acc;
      if (LOAD_REQ)
        r_step_cnt <= '0;
      else if (w_step_acc && (r_step_cnt != c_CNT_MAX))
        r_step_cnt <= r_step_cnt + 4'd1;
    end
  end

  assign LOAD     = r_load;
  assign STEP     = r_step;
  assign SHIFT    = r_load || r_step;
  assign STEP_CNT = r_step_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cv_seq_sched.sv
`default_nettype none
// Testbench for cv_seq_sched: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the scheduling rules.
module tb_cv_seq_sched;
  localparam int PER_W   = 10;
  localparam int BURST_N = 8;

  logic             CLK = 1'b0;
  logic             SYS_NRST;
  logic             CE;
  logic             LOAD_REQ;
  logic             STEP_REQ;
  logic             RUN_REQ;
  logic [PER_W-1:0] PERIOD;
  logic             LOAD;
  logic             STEP;
  logic             SHIFT;
  logic             RUN;
  logic [3:0]       STEP_CNT;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_loaded;
  bit m_run;
  int m_cnt;
  int m_ticks;
  int m_burst;
  bit e_ld;
  bit e_st;

  always #5 CLK = ~CLK;

  cv_seq_sched #(.PER_W(PER_W), .BURST_N(BURST_N)) dut (
    .CLK      (CLK),
    .SYS_NRST (SYS_NRST),
    .CE       (CE),
    .LOAD_REQ (LOAD_REQ),
    .STEP_REQ (STEP_REQ),
    .RUN_REQ  (RUN_REQ),
    .PERIOD   (PERIOD),
    .LOAD     (LOAD),
    .STEP     (STEP),
    .SHIFT    (SHIFT),
    .RUN      (RUN),
    .STEP_CNT (STEP_CNT)
  );

  function automatic void mdl_reset();
    m_loaded = 0; m_run = 0; m_cnt = 0; m_ticks = 0; m_burst = 0;
  endfunction

  // One clock of the scheduling rules; results are what the outputs show next cycle.
  function automatic void mdl(input bit ld, input bit st, input bit rn, input bit ce);
    int per;
    int tick_new;
    bit auto_st;
    bit man_st;
    per      = (PERIOD == 0) ? 1 : int'(PERIOD);
    tick_new = m_ticks + (ce ? 1 : 0);
    auto_st  = 0;
`ifdef CV_SEQ_SCHED_AUTO_EN
    auto_st  = m_run && ce && (tick_new >= per) && !rn && !ld;
`endif
    man_st = m_loaded && st && !ld;
    e_ld   = ld;
    e_st   = auto_st || man_st;
    if (ld) m_cnt = 0;
    else if (e_st && m_cnt < 15) m_cnt = m_cnt + 1;
`ifdef CV_SEQ_SCHED_AUTO_EN
    if (m_run) begin
      m_ticks = (e_st || ld || rn) ? 0 : tick_new;
      if (rn) m_run = 0;
      else if (auto_st) begin
        m_burst = m_burst + 1;
        if (m_burst == BURST_N) m_run = 0;
      end
    end else if (m_loaded && rn) begin
      m_run = 1; m_ticks = 0; m_burst = 0;
    end
`endif
    if (ld) m_loaded = 1;
  endfunction

  task automatic drive(input bit ld, input bit st, input bit rn, input bit ce);
    @(negedge CLK);
    LOAD_REQ = ld; STEP_REQ = st; RUN_REQ = rn; CE = ce;
    mdl(ld, st, rn, ce);
    @(posedge CLK);
    #1;
    LOAD_REQ = 0; STEP_REQ = 0; RUN_REQ = 0; CE = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    SYS_NRST = 0;
    mdl_reset();
    @(negedge CLK);
    SYS_NRST = 1;
  endtask

  task automatic test_reset();
    SYS_NRST = 0; CE = 0; LOAD_REQ = 0; STEP_REQ = 0; RUN_REQ = 0; PERIOD = '0;
    mdl_reset();
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if ({LOAD, STEP, SHIFT, RUN, STEP_CNT} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: got %b, want 00000000", {LOAD, STEP, SHIFT, RUN, STEP_CNT});
    end
    @(negedge CLK);
    SYS_NRST = 1;
  endtask

  task automatic test_idle_step();
    drive(0, 1, 0, 1);
    total++;
    if (STEP !== 1'b0 || SHIFT !== 1'b0) begin
      bad++; $display("FAIL idle_step: STEP=%b SHIFT=%b want 0 0", STEP, SHIFT);
    end
    drive(0, 0, 1, 1);
    total++;
    if (STEP_CNT !== 4'd0 || RUN !== 1'b0) begin
      bad++; $display("FAIL idle_state: STEP_CNT=%0d RUN=%b want 0 0", STEP_CNT, RUN);
    end
  endtask

  task automatic test_manual_steps();
    int shifts = 0;
    drive(1, 0, 0, 0);
    total++;
    if (LOAD !== 1'b1 || STEP !== 1'b0) begin
      bad++; $display("FAIL load_strobe: LOAD=%b STEP=%b want 1 0", LOAD, STEP);
    end
    shifts += SHIFT;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0);
      shifts += SHIFT;
      total++;
      if (STEP !== 1'b1 || LOAD !== 1'b0) begin
        bad++; $display("FAIL step_strobe_%0d: STEP=%b LOAD=%b want 1 0", i, STEP, LOAD);
      end
      drive(0, 0, 0, 0);
      shifts += SHIFT;
      total++;
      if (STEP !== 1'b0) begin
        bad++; $display("FAIL step_width_%0d: STEP=%b want 0", i, STEP);
      end
    end
    total++;
    if (shifts != 4) begin
      bad++; $display("FAIL shift_pulses: got %0d want 4", shifts);
    end
    total++;
    if (STEP_CNT !== 4'd3) begin
      bad++; $display("FAIL step_cnt_3: got %0d want 3", STEP_CNT);
    end
  endtask

  task automatic test_load_step_same();
    drive(1, 1, 0, 0);
    total++;
    if (LOAD !== 1'b1 || STEP !== 1'b0 || STEP_CNT !== 4'd0) begin
      bad++;
      $display("FAIL load_step_same: LOAD=%b STEP=%b CNT=%0d want 1 0 0", LOAD, STEP, STEP_CNT);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 18; i++) drive(0, 1, 0, 0);
    total++;
    if (STEP_CNT !== 4'd15) begin
      bad++; $display("FAIL cnt_saturate: got %0d want 15", STEP_CNT);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) PERIOD = PER_W'($urandom_range(0, 5));
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1);
      total++;
      if ({LOAD, STEP, SHIFT, RUN, STEP_CNT} !== {e_ld, e_st, e_ld | e_st, m_run, 4'(m_cnt)}) begin
        bad++;
        $display("FAIL random_%0d: got L%b S%b SH%b R%b C%0d want L%b S%b SH%b R%b C%0d", i,
                 LOAD, STEP, SHIFT, RUN, STEP_CNT, e_ld, e_st, e_ld | e_st, m_run, m_cnt);
      end
    end
  endtask

`ifdef CV_SEQ_SCHED_AUTO_EN
  task automatic test_burst();
    int nsteps = 0;
    int ce_cnt = 0;
    do_reset();
    PERIOD = PER_W'(3);
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    total++;
    if (RUN !== 1'b1) begin
      bad++; $display("FAIL burst_enter: RUN=%b want 1", RUN);
    end
    for (int i = 0; i < 120 && m_run; i++) begin
      drive(0, 0, 0, i % 2 == 1);
      if (i % 2 == 1) ce_cnt++;
      if (STEP === 1'b1) begin
        nsteps++;
        total++;
        if (ce_cnt % 3 != 0) begin
          bad++; $display("FAIL burst_spacing: step at ce tick %0d want multiple of 3", ce_cnt);
        end
      end
    end
    total++;
    if (nsteps != BURST_N || RUN !== 1'b0 || STEP_CNT !== 4'(BURST_N)) begin
      bad++;
      $display("FAIL burst_end: steps=%0d RUN=%b CNT=%0d want %0d 0 %0d",
               nsteps, RUN, STEP_CNT, BURST_N, BURST_N);
    end
  endtask

  task automatic test_period0_stop();
    do_reset();
    PERIOD = '0;
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1);
      total++;
      if (STEP !== 1'b1 || RUN !== 1'b1) begin
        bad++; $display("FAIL period0_%0d: STEP=%b RUN=%b want 1 1", i, STEP, RUN);
      end
    end
    drive(0, 0, 1, 1);
    total++;
    if (STEP !== 1'b0 || RUN !== 1'b0 || STEP_CNT !== 4'd4) begin
      bad++; $display("FAIL stop_beats_auto: STEP=%b RUN=%b CNT=%0d want 0 0 4", STEP, RUN, STEP_CNT);
    end
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    PERIOD = PER_W'(1);
    drive(1, 0, 0, 0);
`ifdef CV_SEQ_SCHED_AUTO_EN
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 1);
`else
    drive(0, 1, 0, 0);
`endif
    total++;
    if (STEP !== 1'b1) begin
      bad++; $display("FAIL pre_reset_step: STEP=%b want 1", STEP);
    end
    @(negedge CLK);
    #2;
    SYS_NRST = 0;
    #1;
    total++;
    if ({LOAD, STEP, SHIFT, RUN, STEP_CNT} !== 8'h00) begin
      bad++; $display("FAIL async_reset: got %b want 00000000", {LOAD, STEP, SHIFT, RUN, STEP_CNT});
    end
    mdl_reset();
    @(negedge CLK);
    SYS_NRST = 1;
    drive(0, 0, 1, 1);
    drive(0, 1, 0, 1);
    total++;
    if (RUN !== 1'b0 || STEP !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle: RUN=%b STEP=%b want 0 0", RUN, STEP);
    end
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    total++;
    if (RUN !== m_run || STEP_CNT !== 4'd0) begin
      bad++; $display("FAIL reload_run: RUN=%b CNT=%0d want %b 0", RUN, STEP_CNT, m_run);
    end
  endtask

  initial begin
    test_reset();
    test_idle_step();
    test_manual_steps();
    test_load_step_same();
    test_saturation();
    test_random();
`ifdef CV_SEQ_SCHED_AUTO_EN
    test_burst();
    test_period0_stop();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
